// File: rtl/ps2_keyboard_if.sv
// Character port between the PS/2 keyboard front end and the MMU.
// The keyboard side drives the character head and status; the MMU side
// drives the read strobe that pops the head.
interface ps2_keyboard_if;
    logic       kb_data_receive;
    logic       kb_data_ready;
    logic [7:0] kb_ascii;
    logic       kb_parity_err;

    modport master (
        input  kb_data_receive,
        output kb_data_ready,
        output kb_ascii,
        output kb_parity_err
    );

    modport slave (
        output kb_data_receive,
        input  kb_data_ready,
        input  kb_ascii,
        input  kb_parity_err
    );
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: synchronises the PS/2 pins, deframes 11-bit
// frames, tracks shift/break/extended prefixes, translates scancode set 2
// to ASCII and buffers characters in a small FIFO read by the MMU.
module ps2_keyboard #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    ps2_keyboard_if.master kb
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    // Scancode set 2 make code -> {mapped, ascii}; letters follow shift.
    function automatic logic [8:0] set2_ascii(input logic [7:0] code, input logic shift);
        logic [7:0] ch;
        logic       valid;
        logic       letter;
        ch     = 8'h00;
        valid  = 1'b1;
        letter = 1'b1;
        case (code)
            8'h1C: ch = "a";
            8'h32: ch = "b";
            8'h21: ch = "c";
            8'h23: ch = "d";
            8'h24: ch = "e";
            8'h2B: ch = "f";
            8'h34: ch = "g";
            8'h33: ch = "h";
            8'h43: ch = "i";
            8'h3B: ch = "j";
            8'h42: ch = "k";
            8'h4B: ch = "l";
            8'h3A: ch = "m";
            8'h31: ch = "n";
            8'h44: ch = "o";
            8'h4D: ch = "p";
            8'h15: ch = "q";
            8'h2D: ch = "r";
            8'h1B: ch = "s";
            8'h2C: ch = "t";
            8'h3C: ch = "u";
            8'h2A: ch = "v";
            8'h1D: ch = "w";
            8'h22: ch = "x";
            8'h35: ch = "y";
            8'h1A: ch = "z";
            8'h45: begin ch = "0"; letter = 1'b0; end
            8'h16: begin ch = "1"; letter = 1'b0; end
            8'h1E: begin ch = "2"; letter = 1'b0; end
            8'h26: begin ch = "3"; letter = 1'b0; end
            8'h25: begin ch = "4"; letter = 1'b0; end
            8'h2E: begin ch = "5"; letter = 1'b0; end
            8'h36: begin ch = "6"; letter = 1'b0; end
            8'h3D: begin ch = "7"; letter = 1'b0; end
            8'h3E: begin ch = "8"; letter = 1'b0; end
            8'h46: begin ch = "9"; letter = 1'b0; end
            8'h29: begin ch = 8'h20; letter = 1'b0; end
            8'h5A: begin ch = 8'h0D; letter = 1'b0; end
            8'h66: begin ch = 8'h08; letter = 1'b0; end
            8'h76: begin ch = 8'h1B; letter = 1'b0; end
            default: begin valid = 1'b0; letter = 1'b0; end
        endcase
        if (letter && shift) begin
            ch = ch - 8'h20;
        end
        return {valid, ch};
    endfunction

    logic clk_sync_p0, clk_sync_p1, clk_prev;
    logic data_sync_p0, data_sync_p1;
    logic fall;

    state_t        state, state_nx;
    logic [3:0]    bit_cnt, bit_cnt_nx;
    logic [9:0]    shreg, shreg_nx;
    logic [TW-1:0] to_cnt;
    logic          timed_out;
    logic          frame_ok, frame_bad;

    logic          vld_p2;
    logic [7:0]    byte_p2;

    logic          ext_flag, brk_flag, shift_flag;
    logic          ext_nx, brk_nx, shift_nx;
    logic          push;
    logic [7:0]    push_data;
    logic [8:0]    map;

    logic          recv_q, recv_prev;
    logic          pop_req, do_pop, do_push;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    // Two-flop synchronisers for the asynchronous PS/2 pins plus edge history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_p0  <= 1'b1;
            clk_sync_p1  <= 1'b1;
            clk_prev     <= 1'b1;
            data_sync_p0 <= 1'b1;
            data_sync_p1 <= 1'b1;
        end else begin
            clk_sync_p0  <= ps2_clk;
            clk_sync_p1  <= clk_sync_p0;
            clk_prev     <= clk_sync_p1;
            data_sync_p0 <= ps2_data;
            data_sync_p1 <= data_sync_p0;
        end
    end

    assign fall      = clk_prev & ~clk_sync_p1;
    assign timed_out = (to_cnt == TIMEOUT_C);

    // Frame state register, bit counter and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
            shreg   <= 10'd0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            shreg   <= shreg_nx;
        end
    end

    // Frame next-state: start bit, ten shifted bits, one-cycle check, timeout.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !data_sync_p1) begin
                    state_nx   = SHIFT;
                    bit_cnt_nx = 4'd0;
                end
            end
            SHIFT: begin
                if (fall) begin
                    shreg_nx   = {data_sync_p1, shreg[9:1]};
                    bit_cnt_nx = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9) begin
                        state_nx = CHECK;
                    end
                end else if (timed_out) begin
                    state_nx = IDLE;
                end
            end
            CHECK: begin
                state_nx = IDLE;
                if ((^shreg[8:0]) && shreg[9]) begin
                    frame_ok = 1'b1;
                end else begin
                    frame_bad = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Inactivity counter: cleared by every falling edge and while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (fall || state == IDLE) begin
            to_cnt <= '0;
        end else if (!timed_out) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // CHECK result: hand a good byte to the decoder, flag a dropped frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p2           <= 1'b0;
            kb.kb_parity_err <= 1'b0;
        end else begin
            vld_p2           <= frame_ok;
            kb.kb_parity_err <= frame_bad;
        end
    end

    // Received byte travels alongside vld_p2 and needs no reset.
    always_ff @(posedge clk) begin
        byte_p2 <= shreg[7:0];
    end

    assign map = set2_ascii(byte_p2, shift_flag);

    // Decoder: prefix tracking, shift state and the push decision.
    always_comb begin
        ext_nx    = ext_flag;
        brk_nx    = brk_flag;
        shift_nx  = shift_flag;
        push      = 1'b0;
        push_data = map[7:0];
        if (vld_p2) begin
            if (byte_p2 == 8'hE0) begin
                ext_nx = 1'b1;
            end else if (byte_p2 == 8'hF0) begin
                brk_nx = 1'b1;
            end else if (ext_flag) begin
                ext_nx = 1'b0;
                brk_nx = 1'b0;
            end else if (brk_flag) begin
                brk_nx = 1'b0;
                if (byte_p2 == 8'h12 || byte_p2 == 8'h59) begin
                    shift_nx = 1'b0;
                end
            end else if (byte_p2 == 8'h12 || byte_p2 == 8'h59) begin
                shift_nx = 1'b1;
            end else begin
                push = map[8];
            end
        end
    end

    // Decoder flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            shift_flag <= 1'b0;
        end else begin
            ext_flag   <= ext_nx;
            brk_flag   <= brk_nx;
            shift_flag <= shift_nx;
        end
    end

    // Read strobe history; idles high so reset never fakes a rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            recv_q    <= 1'b1;
            recv_prev <= 1'b1;
        end else begin
            recv_q    <= kb.kb_data_receive;
            recv_prev <= recv_q;
        end
    end

    assign pop_req = recv_q & ~recv_prev;
    assign do_pop  = pop_req && (count != '0);
    assign do_push = push && ((count != DEPTH_C) || do_pop);

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Registered head presented to the MMU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kb.kb_data_ready <= 1'b0;
            kb.kb_ascii      <= 8'h00;
        end else begin
            kb.kb_data_ready <= (count != '0);
            kb.kb_ascii      <= (count != '0) ? mem[rd_ptr] : 8'h00;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: drives PS/2 frames and MMU read strobes.
module tb_ps2_keyboard;

    localparam int HALF  = 10;
    localparam int DEPTH = 8;
    localparam int TO    = 300;

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    int checks     = 0;
    int errors     = 0;
    int err_cycles = 0;

    ps2_keyboard_if kb();

    ps2_keyboard #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .kb       (kb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (kb.kb_parity_err === 1'b1) err_cycles <= err_cycles + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_fall(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
    endtask

    task automatic ps2_rise();
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_fall(b);
        ps2_rise();
    endtask

    // Start bit, eight data bits LSB first, odd parity (optionally corrupted).
    task automatic send_head(input logic [7:0] code, input logic bad);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit((~^code) ^ bad);
    endtask

    task automatic send_frame(input logic [7:0] code);
        send_head(code, 1'b0);
        ps2_bit(1'b1);
        repeat (8) @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk) kb.kb_data_receive = 1'b0;
        repeat (3) @(negedge clk);
        kb.kb_data_receive = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [7:0] fill [8];
        logic [7:0] seq2 [7];
        logic [7:0] exp4 [8];
        fill = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33};
        seq2 = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
        exp4 = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};

        // Reset state
        kb.kb_data_receive = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(kb.kb_data_ready), 32'd0);
        check("rst_ascii", 32'(kb.kb_ascii), 32'h00);
        check("rst_err", 32'(kb.kb_parity_err), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready", 32'(kb.kb_data_ready), 32'd0);

        // 1: frame 1C, ready exactly six clocks after the stop edge
        send_head(8'h1C, 1'b0);
        ps2_fall(1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("t1_ready_at5", 32'(kb.kb_data_ready), 32'd0);
        @(posedge clk);
        #1;
        check("t1_ready_at6", 32'(kb.kb_data_ready), 32'd1);
        check("t1_ascii", 32'(kb.kb_ascii), 32'h61);
        ps2_rise();
        repeat (8) @(negedge clk);
        check("t1_err", 32'(err_cycles), 32'd0);
        pop();
        check("t1_empty", 32'(kb.kb_data_ready), 32'd0);

        // 2: shift make/break sequence
        for (int i = 0; i < 7; i++) send_frame(seq2[i]);
        check("t2_head", 32'(kb.kb_ascii), 32'h41);
        check("t2_ready", 32'(kb.kb_data_ready), 32'd1);
        pop();
        check("t2_second", 32'(kb.kb_ascii), 32'h61);
        check("t2_ready2", 32'(kb.kb_data_ready), 32'd1);
        pop();
        check("t2_ascii_empty", 32'(kb.kb_ascii), 32'h00);
        check("t2_ready_empty", 32'(kb.kb_data_ready), 32'd0);

        // 3: overfill with spaces, then drain
        for (int i = 0; i < DEPTH + 2; i++) send_frame(8'h29);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("t3_ready_%0d", i), 32'(kb.kb_data_ready), 32'd1);
            check($sformatf("t3_ascii_%0d", i), 32'(kb.kb_ascii), 32'h20);
            pop();
        end
        check("t3_empty", 32'(kb.kb_data_ready), 32'd0);
        check("t3_ascii0", 32'(kb.kb_ascii), 32'h00);

        // 4: full FIFO, push and pop land on the same clock
        for (int i = 0; i < DEPTH; i++) send_frame(fill[i]);
        check("t4_full_head", 32'(kb.kb_ascii), 32'h61);
        @(negedge clk) kb.kb_data_receive = 1'b0;
        repeat (3) @(negedge clk);
        send_head(8'h43, 1'b0);
        ps2_fall(1'b1);
        repeat (3) @(negedge clk);
        kb.kb_data_receive = 1'b1;
        ps2_rise();
        repeat (8) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("t4_ready_%0d", i), 32'(kb.kb_data_ready), 32'd1);
            check($sformatf("t4_ascii_%0d", i), 32'(kb.kb_ascii), 32'(exp4[i]));
            pop();
        end
        check("t4_empty", 32'(kb.kb_data_ready), 32'd0);

        // 5: parity error, then abandoned partial frame and timeout
        send_head(8'h1C, 1'b1);
        ps2_bit(1'b1);
        repeat (8) @(negedge clk);
        check("t5_err_cycles", 32'(err_cycles), 32'd1);
        check("t5_no_push", 32'(kb.kb_data_ready), 32'd0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        repeat (TO + 100) @(negedge clk);
        send_frame(8'h45);
        check("t5_ascii", 32'(kb.kb_ascii), 32'h30);
        check("t5_ready", 32'(kb.kb_data_ready), 32'd1);
        check("t5_err_after", 32'(err_cycles), 32'd1);
        pop();
        check("t5_only_one", 32'(kb.kb_data_ready), 32'd0);

        // 6: reset mid-frame with characters buffered and shift held
        send_frame(8'h1C);
        send_frame(8'h32);
        send_frame(8'h21);
        send_frame(8'h12);
        check("t6_pre_ascii", 32'(kb.kb_ascii), 32'h61);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        check("t6_rst_ready", 32'(kb.kb_data_ready), 32'd0);
        check("t6_rst_ascii", 32'(kb.kb_ascii), 32'h00);
        repeat (4) @(negedge clk);
        send_frame(8'h5A);
        check("t6_ascii", 32'(kb.kb_ascii), 32'h0D);
        check("t6_ready", 32'(kb.kb_data_ready), 32'd1);
        send_frame(8'h1C);
        pop();
        check("t6_shift_cleared", 32'(kb.kb_ascii), 32'h61);
        pop();
        check("t6_empty", 32'(kb.kb_data_ready), 32'd0);
        check("t6_err", 32'(err_cycles), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
